// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds funct3 codes, FSM state encoding and the funct3 legality check.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic logic is_legal(
      input logic       write,
      input logic [2:0] funct3
   );
      if (write)
         return funct3 inside {F3_B, F3_H, F3_W};
      return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between core (master) and memory responder (slave).
// Request channel: req_*; response channel: rsp_*; both valid/ready.
interface dmem_responder_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic [2:0]               req_funct3;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_WIDTH-1:0]    rsp_rdata;
   logic                     rsp_err;

   modport master (
      output req_valid, req_write, req_addr,
      output req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr,
      input  req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Lane steering: byte enables and replicated store word from offset/funct3,
// and the sign/zero-extended load result from the raw array word.
module lsu_align
   import dmem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] ldata
);

   logic [15:0] sh;

   // selected lane(s) moved down to bit 0
   assign sh = 16'(raw >> {off, 3'b000});

   always_comb begin
      be    = '0;
      wword = '0;
      unique case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {off[1], 1'b0};
            wword = {2{wdata[15:0]}};
         end
         2'b10: begin
            be    = 4'b1111;
            wword = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      ldata = '0;
      unique case (funct3)
         F3_B:    ldata = {{24{sh[7]}}, sh[7:0]};
         F3_H:    ldata = {{16{sh[15]}}, sh[15:0]};
         F3_W:    ldata = raw;
         F3_BU:   ldata = {24'b0, sh[7:0]};
         F3_HU:   ldata = {16'b0, sh[15:0]};
         default: ldata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Stallable data memory: one request at a time, LATENCY wait cycles,
// masked stores and extended loads. Ports: clk, rst, bus (slave side).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH_WORDS   = 1024,
   parameter int LATENCY       = 2
) (
   input  logic           clk,
   input  logic           rst,
   dmem_responder_if.slave bus
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
   localparam logic [ADDRESS_WIDTH:0] LIMIT =
      (ADDRESS_WIDTH + 1)'(DEPTH_WORDS * 4);

   state_t state, state_nx;

   logic [CW-1:0]            cnt;
   logic                     cap_write;
   logic [ADDRESS_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0]    cap_wdata;
   logic [2:0]               cap_f3;
   logic [DATA_WIDTH-1:0]    rdata_q;
   logic                     err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic                     accept, exec, hsk;
   logic                     x_write;
   logic [ADDRESS_WIDTH-1:0] x_addr;
   logic [DATA_WIDTH-1:0]    x_wdata;
   logic [2:0]               x_f3;
   logic                     misal, oor, err, we;
   logic [IW-1:0]            idx;
   logic [31:0]              raw, wword, ldata;
   logic [3:0]               be;

   assign accept = (state == IDLE) && bus.req_valid;
   assign exec   = (accept && (LATENCY == 0)) ||
                   ((state == WAIT) && (cnt == CW'(1)));
   assign hsk    = (state == RESP) && bus.rsp_ready;

   // zero latency executes straight off the live request
   assign x_write = (state == IDLE) ? bus.req_write  : cap_write;
   assign x_addr  = (state == IDLE) ? bus.req_addr   : cap_addr;
   assign x_wdata = (state == IDLE) ? bus.req_wdata  : cap_wdata;
   assign x_f3    = (state == IDLE) ? bus.req_funct3 : cap_f3;

   always_comb begin
      misal = 1'b0;
      unique case (x_f3[1:0])
         2'b01:   misal = x_addr[0];
         2'b10:   misal = |x_addr[1:0];
         default: misal = 1'b0;
      endcase
   end

   assign oor = {1'b0, x_addr} >= LIMIT;
   assign err = !is_legal(x_write, x_f3) || misal || oor;
   assign idx = x_addr[IW+1:2];
   assign raw = mem[idx];
   assign we  = exec && x_write && !err && !rst;

   lsu_align u_align (
      .off    (x_addr[1:0]),
      .funct3 (x_f3),
      .wdata  (x_wdata),
      .raw    (raw),
      .be     (be),
      .wword  (wword),
      .ldata  (ldata)
   );

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.req_valid)
                  state_nx = (LATENCY == 0) ? RESP : WAIT;
         WAIT: if (cnt == CW'(1))
                  state_nx = RESP;
         RESP: if (bus.rsp_ready)
                  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_f3    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= CW'(LATENCY);
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_f3    <= bus.req_funct3;
         end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
         end
         if (exec) begin
            rdata_q <= (err || x_write) ? '0 : ldata;
            err_q   <= err;
         end else if (hsk) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 and LATENCY=0.
// A shared stimulus bus is steered to one instance at a time via sel.
module tb_dmem_responder;
   import dmem_pkg::*;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        req_valid, req_write, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   dmem_responder_if b2 ();
   dmem_responder_if b0 ();

   assign b2.req_valid  = req_valid & ~sel;
   assign b2.req_write  = req_write;
   assign b2.req_addr   = req_addr;
   assign b2.req_wdata  = req_wdata;
   assign b2.req_funct3 = req_funct3;
   assign b2.rsp_ready  = rsp_ready | sel;

   assign b0.req_valid  = req_valid & sel;
   assign b0.req_write  = req_write;
   assign b0.req_addr   = req_addr;
   assign b0.req_wdata  = req_wdata;
   assign b0.req_funct3 = req_funct3;
   assign b0.rsp_ready  = rsp_ready | ~sel;

   assign req_ready = sel ? b0.req_ready : b2.req_ready;
   assign rsp_valid = sel ? b0.rsp_valid : b2.rsp_valid;
   assign rsp_rdata = sel ? b0.rsp_rdata : b2.rsp_rdata;
   assign rsp_err   = sel ? b0.rsp_err   : b2.rsp_err;

   dmem_responder #(.LATENCY(2)) u_l2 (
      .clk (clk),
      .rst (rst),
      .bus (b2.slave)
   );

   dmem_responder #(.LATENCY(0)) u_l0 (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   int   tests = 0;
   int   fails = 0;
   vec_t vq[$];

   function automatic int cur_lat();
      return sel ? 0 : 2;
   endfunction

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s lat=%0d: got %h, want %h",
                  nm, cur_lat(), act, exp);
      end
   endtask

   task automatic txn(input  logic        w,
                      input  logic [31:0] a,
                      input  logic [31:0] d,
                      input  logic [2:0]  f3,
                      output logic [31:0] rd,
                      output logic        er);
      int   edges;
      logic saw_ready;
      @(negedge clk);
      check("ready_before", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      edges     = 1;
      saw_ready = req_ready;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
         saw_ready = saw_ready | req_ready;
      end
      check("rsp_edges", 32'(edges), 32'(cur_lat() + 1));
      check("ready_low", 32'(saw_ready), 32'd0);
      rd = rsp_rdata;
      er = rsp_err;
      if (rsp_ready) begin
         @(posedge clk);
         #1;
         check("idle_after", {30'b0, req_ready, rsp_valid}, 32'd2);
      end
   endtask

   task automatic run_all();
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < vq.size(); i++) begin
         txn(vq[i].w, vq[i].a, vq[i].d, vq[i].f3, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vq[i].er);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].ee));
      end

      // backpressure with an ignored store attempt while busy
      @(negedge clk);
      rsp_ready = 1'b0;
      txn(1'b0, 32'h10, 32'h0, F3_W, rd, er);
      check("bp_first", rd, 32'hDE7FBEEF);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h10;
      req_wdata  = 32'h0;
      req_funct3 = F3_W;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_flags", {29'b0, rsp_valid, req_ready, rsp_err},
               32'd4);
         check("bp_rdata", rsp_rdata, 32'hDE7FBEEF);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {30'b0, req_ready, rsp_valid}, 32'd2);
      txn(1'b0, 32'h10, 32'h0, F3_W, rd, er);
      check("bp_ignored", rd, 32'hDE7FBEEF);

      // reset mid-transaction: WAIT at LATENCY=2, RESP at LATENCY=0
      @(negedge clk);
      rsp_ready  = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h20;
      req_wdata  = 32'h12345678;
      req_funct3 = F3_W;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rst_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_flags", {29'b0, req_ready, rsp_valid, rsp_err}, 32'd4);
      check("rst_rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      txn(1'b0, 32'h20, 32'h0, F3_W, rd, er);
      check("rst_mem", rd, sel ? 32'h12345678 : 32'hA5A5A5A5);
   endtask

   initial begin
      rst        = 1'b1;
      sel        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      rsp_ready  = 1'b1;

      vq.push_back('{1'b1, 32'h10,   32'hDEADBEEF, F3_W,  32'h0,        1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        F3_W,  32'hDEADBEEF, 1'b0});
      vq.push_back('{1'b1, 32'h12,   32'h0000007F, F3_B,  32'h0,        1'b0});
      vq.push_back('{1'b0, 32'h12,   32'h0,        F3_BU, 32'h0000007F, 1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        F3_W,  32'hDE7FBEEF, 1'b0});
      vq.push_back('{1'b0, 32'h13,   32'h0,        F3_B,  32'hFFFFFFDE, 1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        F3_H,  32'hFFFFBEEF, 1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        F3_HU, 32'h0000BEEF, 1'b0});
      vq.push_back('{1'b0, 32'h11,   32'h0,        F3_H,  32'h0,        1'b1});
      vq.push_back('{1'b1, 32'h12,   32'h11111111, F3_W,  32'h0,        1'b1});
      vq.push_back('{1'b0, 32'h10,   32'h0,        F3_W,  32'hDE7FBEEF, 1'b0});
      vq.push_back('{1'b1, 32'h0,    32'h13579BDF, F3_W,  32'h0,        1'b0});
      vq.push_back('{1'b1, 32'h1000, 32'h55555555, F3_W,  32'h0,        1'b1});
      vq.push_back('{1'b0, 32'h0,    32'h0,        F3_W,  32'h13579BDF, 1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,       1'b1});
      vq.push_back('{1'b1, 32'h14,   32'h01234567, F3_W,  32'h0,        1'b0});
      vq.push_back('{1'b1, 32'h14,   32'hAAAAAAAA, 3'b011, 32'h0,       1'b1});
      vq.push_back('{1'b1, 32'h16,   32'h0000CAFE, F3_H,  32'h0,        1'b0});
      vq.push_back('{1'b1, 32'h15,   32'hFFFFFF80, F3_B,  32'h0,        1'b0});
      vq.push_back('{1'b0, 32'h14,   32'h0,        F3_W,  32'hCAFE8067, 1'b0});
      vq.push_back('{1'b0, 32'h15,   32'h0,        F3_B,  32'hFFFFFF80, 1'b0});
      vq.push_back('{1'b0, 32'h14,   32'h0,        F3_H,  32'hFFFF8067, 1'b0});
      vq.push_back('{1'b0, 32'h1000, 32'h0,        F3_W,  32'h0,        1'b1});
      vq.push_back('{1'b1, 32'hFFC,  32'h89ABCDEF, F3_W,  32'h0,        1'b0});
      vq.push_back('{1'b0, 32'hFFC,  32'h0,        F3_W,  32'h89ABCDEF, 1'b0});
      vq.push_back('{1'b0, 32'hFFE,  32'h0,        F3_HU, 32'h000089AB, 1'b0});
      vq.push_back('{1'b0, 32'h10,   32'h0,        3'b110, 32'h0,       1'b1});
      vq.push_back('{1'b1, 32'h20,   32'hA5A5A5A5, F3_W,  32'h0,        1'b0});

      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("reset_flags", {29'b0, req_ready, rsp_valid, rsp_err},
               32'd4);
         check("reset_rdata", rsp_rdata, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      sel = 1'b0;

      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         sel = s[0];
         run_all();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Accepts one request at a time over a valid/ready handshake and applies a configurable access latency.
- Performs byte/half/word stores with lane masking, and loads with sign or zero extension.
- Returns the result over a second valid/ready channel; replaces the zero-latency data memory once the core moves to a stallable memory interface.

Parameters:
ADDRESS_WIDTH, 32, width of request address
DATA_WIDTH, 32, width of data bus (fixed at 32 for RV32)
DEPTH_WORDS, 1024, number of 32-bit words in the array; addresses at or above DEPTH_WORDS*4 are out of range
LATENCY, 2, WAIT cycles between request acceptance and response (0 allowed)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDRESS_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data (low-aligned: byte in [7:0], half in [15:0])
req_funct3  input  3  RV32 load/store funct3
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-high (rst). On rst high at a clock edge:
  - state=IDLE, req_ready=1 (combinational from state), rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are not reset.
  - Reset mid-transaction drops any uncommitted store; a store already committed stays in the array.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture write/addr/wdata/funct3 and load counter with LATENCY. Go to WAIT if LATENCY>0, else EXEC directly (see below).
  - WAIT: req_ready=0. Decrement counter each cycle. When counter reaches 1, EXEC occurs on the next edge.
  - EXEC is the single edge that leaves WAIT, or leaves IDLE when LATENCY=0. On that edge:
    - legality check;
    - array write (stores) or array read into rsp_rdata (loads);
    - rsp_err set;
    - rsp_valid set to 1;
    - state becomes RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that handshake, rsp_valid=0 and state becomes IDLE.
- Timing:
  - No new request is accepted in the handshake cycle.
  - Minimum transaction period is LATENCY+2 cycles.
  - Response is visible LATENCY+1 edges after acceptance.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal and sets rsp_err.
- Errors:
  - Alignment: halfword with addr[0]=1, or word with addr[1:0]!=0, sets rsp_err.
  - Range: addr >= DEPTH_WORDS*4 sets rsp_err.
  - On any error: no array write, rsp_rdata=0.
  - Priority: illegal funct3 is reported first, but all error cases raise the same single flag.
- Data layout:
  - Little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store masks: SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes addr[1]*2 and +1 with wdata[15:0]. SW writes all four lanes.
  - LB/LH sign-extend from bit 7/15 of the selected lane(s); LBU/LHU zero-extend.
  - Stores return rsp_rdata=0, rsp_err=0 on success.
- req_valid while req_ready=0 is ignored, not queued. The requester must hold the request until req_ready is seen.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - typedef enum logic [1:0] state_t {IDLE, WAIT, RESP};
  - function is_legal(write, funct3).
- One combinational sub-module, lsu_align, produces the 4-bit byte-enable, the shifted store word, and the extended load result from addr[1:0], funct3 and raw word.
- Array, FSM and counter stay in dmem_responder.

Test Plan:
- LATENCY=2, rsp_ready tied high: SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. Each response appears 3 edges after its accept; req_ready is low for 3 cycles.
- After that word: SB 0x7F to 0x12, then LBU from 0x12 -> 0x0000007F. LW from 0x10 -> 0xDE7FBEEF. LB from 0x13 -> 0xFFFFFFDE. LH from 0x10 -> 0xFFFFBEEF. LHU from 0x10 -> 0x0000BEEF.
- LH from 0x11 and SW to 0x12 -> rsp_err=1, rsp_rdata=0. A following LW from 0x10 shows the array unchanged.
- Addr DEPTH_WORDS*4 (0x1000) and funct3=011 -> rsp_err=1, no write.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. On rsp_ready=1, IDLE is reached one edge later.
- Reset mid-WAIT during SW 0x12345678 to 0x20: after rst, outputs are at reset values. LW from 0x20 returns the prior contents. Repeat every scenario with LATENCY=0 (response 1 edge after accept).
